// File: rtl/alarm_trigger.sv
// Alarm trigger: stores the alarm handed over by the setter, watches the
// running clock time for a match, and sequences ring / snooze / stop / timeout.
// Reset port `rst` is asynchronous and active-low.
module alarm_trigger #(
  parameter int RING_SECS  = 60,  // sec_tick pulses before auto-off (>=1)
  parameter int SNOOZE_MIN = 5,   // minutes added on snooze (1..59)
  parameter int MAX_SNOOZE = 3    // snoozes allowed per alarm event (>=1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sec_tick,
  input  logic [4:0]                      cur_hours,
  input  logic [5:0]                      cur_minutes,
  input  logic [5:0]                      cur_seconds,
  input  logic [4:0]                      alarm_hours,
  input  logic [5:0]                      alarm_minutes,
  input  logic                            alarm_on,
  input  logic                            alarm_ack,
  input  logic                            stop_button,
  input  logic                            snooze_button,
  output logic                            buzzer,
  output logic                            snoozing,
  output logic                            armed,
  output logic                            alarm_invalid,
  output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_cnt
);

  localparam int SNW = $clog2(MAX_SNOOZE + 1);
  localparam int RW  = $clog2(RING_SECS + 1);

  localparam logic [SNW-1:0] MAX_SNOOZE_C = SNW'(MAX_SNOOZE);
  localparam logic [RW-1:0]  RING_SECS_C  = RW'(RING_SECS);
  localparam logic [6:0]     SNOOZE_MIN_C = 7'(SNOOZE_MIN);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RINGING  = 2'd1,
    SNOOZING = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [4:0]     alm_h_q, alm_h_d;
  logic [5:0]     alm_m_q, alm_m_d;
  logic [4:0]     snz_h_q, snz_h_d;
  logic [5:0]     snz_m_q, snz_m_d;
  logic           armed_q, armed_d;
  logic           invalid_q, invalid_d;
  logic [SNW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic [RW-1:0]  ring_cnt_q, ring_cnt_d;
  logic           match_prev_q, match_prev_d;

  logic [4:0] tgt_h;
  logic [5:0] tgt_m;
  logic       match_now;
  logic       match_event;
  logic       load_valid;
  logic [6:0] sum_m;
  logic [5:0] next_snz_m;
  logic [4:0] next_snz_h;
  logic [RW-1:0] ring_cnt_inc;

  // Compare against the snooze target while snoozing, otherwise the stored alarm;
  // only the rising edge of a match counts so a held match fires once.
  always_comb begin
    tgt_h       = (state_q == SNOOZING) ? snz_h_q : alm_h_q;
    tgt_m       = (state_q == SNOOZING) ? snz_m_q : alm_m_q;
    match_now   = (cur_hours == tgt_h) && (cur_minutes == tgt_m) && (cur_seconds == 6'd0);
    match_event = match_now && !match_prev_q;
  end

  // Snooze target = current time plus SNOOZE_MIN minutes, wrapping past midnight.
  always_comb begin
    sum_m      = {1'b0, cur_minutes} + SNOOZE_MIN_C;
    next_snz_h = cur_hours;
    next_snz_m = cur_minutes;
    if (sum_m >= 7'd60) begin
      next_snz_m = 6'(sum_m - 7'd60);
      next_snz_h = cur_hours + 5'd1;
    end else begin
      next_snz_m = 6'(sum_m);
    end
    if (next_snz_h == 5'd24) next_snz_h = 5'd0;
  end

  // Next-state logic: alarm_ack overrides everything, then stop, snooze, timeout/event.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    alm_h_d      = alm_h_q;
    alm_m_d      = alm_m_q;
    snz_h_d      = snz_h_q;
    snz_m_d      = snz_m_q;
    armed_d      = armed_q;
    invalid_d    = invalid_q;
    snooze_cnt_d = snooze_cnt_q;
    ring_cnt_d   = ring_cnt_q;
    match_prev_d = match_now;
    load_valid   = (alarm_hours <= 5'd23) && (alarm_minutes <= 6'd59);
    ring_cnt_inc = ring_cnt_q + RW'(1);

    if (alarm_ack) begin
      alm_h_d      = alarm_hours;
      alm_m_d      = alarm_minutes;
      armed_d      = alarm_on && load_valid;
      invalid_d    = !load_valid;
      state_d      = IDLE;
      snooze_cnt_d = '0;
      ring_cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (match_event && armed_q) begin
            state_d      = RINGING;
            ring_cnt_d   = '0;
            snooze_cnt_d = '0;
          end
        end
        RINGING: begin
          if (stop_button) begin
            state_d = IDLE;
          end else if (snooze_button) begin
            if (snooze_cnt_q < MAX_SNOOZE_C) begin
              state_d      = SNOOZING;
              snooze_cnt_d = snooze_cnt_q + SNW'(1);
              snz_h_d      = next_snz_h;
              snz_m_d      = next_snz_m;
            end else begin
              state_d = IDLE;
            end
          end else if (sec_tick) begin
            ring_cnt_d = ring_cnt_inc;
            if (ring_cnt_inc == RING_SECS_C) state_d = IDLE;
          end
        end
        SNOOZING: begin
          if (stop_button) begin
            state_d      = IDLE;
            snooze_cnt_d = '0;
          end else if (match_event) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and storage registers; async reset clears the stored alarm too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      alm_h_q      <= '0;
      alm_m_q      <= '0;
      snz_h_q      <= '0;
      snz_m_q      <= '0;
      armed_q      <= 1'b0;
      invalid_q    <= 1'b0;
      snooze_cnt_q <= '0;
      ring_cnt_q   <= '0;
      match_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      alm_h_q      <= alm_h_d;
      alm_m_q      <= alm_m_d;
      snz_h_q      <= snz_h_d;
      snz_m_q      <= snz_m_d;
      armed_q      <= armed_d;
      invalid_q    <= invalid_d;
      snooze_cnt_q <= snooze_cnt_d;
      ring_cnt_q   <= ring_cnt_d;
      match_prev_q <= match_prev_d;
    end
  end

  // Outputs decoded purely from registers.
  assign buzzer        = (state_q == RINGING);
  assign snoozing      = (state_q == SNOOZING);
  assign armed         = armed_q;
  assign alarm_invalid = invalid_q;
  assign snooze_cnt    = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: expected output tuples are queued as
// stimulus is driven and compared after the following clock edge.
module tb_alarm_trigger;

  logic       clk = 1'b0;
  logic       rst;
  logic       sec_tick;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_on;
  logic       alarm_ack;
  logic       stop_button;
  logic       snooze_button;
  logic       buzzer;
  logic       snoozing;
  logic       armed;
  logic       alarm_invalid;
  logic [1:0] snooze_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct {
    string      tag;
    logic       buzzer;
    logic       snoozing;
    logic       armed;
    logic       invalid;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  alarm_trigger #(.RING_SECS(60), .SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .sec_tick      (sec_tick),
    .cur_hours     (cur_hours),
    .cur_minutes   (cur_minutes),
    .cur_seconds   (cur_seconds),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes),
    .alarm_on      (alarm_on),
    .alarm_ack     (alarm_ack),
    .stop_button   (stop_button),
    .snooze_button (snooze_button),
    .buzzer        (buzzer),
    .snoozing      (snoozing),
    .armed         (armed),
    .alarm_invalid (alarm_invalid),
    .snooze_cnt    (snooze_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_hours   = 5'(h);
    cur_minutes = 6'(m);
    cur_seconds = 6'(s);
  endtask

  task automatic expect_out(input string tag, input logic b, input logic sn,
                            input logic a, input logic inv, input logic [1:0] c);
    exp_t e;
    e.tag = tag; e.buzzer = b; e.snoozing = sn; e.armed = a; e.invalid = inv; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic check_one(input string tag, input string field,
                           input logic [1:0] obs, input logic [1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  // Pop every queued expectation and compare against the current outputs.
  task automatic check_outputs();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_one(e.tag, "buzzer",   {1'b0, buzzer},        {1'b0, e.buzzer});
      check_one(e.tag, "snoozing", {1'b0, snoozing},      {1'b0, e.snoozing});
      check_one(e.tag, "armed",    {1'b0, armed},         {1'b0, e.armed});
      check_one(e.tag, "invalid",  {1'b0, alarm_invalid}, {1'b0, e.invalid});
      check_one(e.tag, "cnt",      snooze_cnt,            e.cnt);
    end
  endtask

  // Drive one cycle, queue its expected post-edge outputs, compare after the edge.
  task automatic cyc(input string tag, input logic b, input logic sn,
                     input logic a, input logic inv, input logic [1:0] c);
    expect_out(tag, b, sn, a, inv, c);
    step();
    check_outputs();
  endtask

  task automatic load(input int h, input int m, input logic on);
    alarm_hours   = 5'(h);
    alarm_minutes = 6'(m);
    alarm_on      = on;
    alarm_ack     = 1'b1;
  endtask

  task automatic release_inputs();
    alarm_ack     = 1'b0;
    stop_button   = 1'b0;
    snooze_button = 1'b0;
    sec_tick      = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    release_inputs();
    alarm_on = 1'b0; alarm_hours = '0; alarm_minutes = '0;
    set_time(7, 29, 59);
    #12;
    expect_out("reset", 0, 0, 0, 0, 2'd0);
    check_outputs();
    rst = 1'b1;

    // 1: load 07:30 on, clock crosses 07:30:00, fires once
    load(7, 30, 1'b1);
    cyc("t1_load", 0, 0, 1, 0, 2'd0);
    release_inputs();
    cyc("t1_pre", 0, 0, 1, 0, 2'd0);
    set_time(7, 30, 0);
    cyc("t1_fire", 1, 0, 1, 0, 2'd0);
    cyc("t1_hold", 1, 0, 1, 0, 2'd0);
    stop_button = 1'b1;
    cyc("t1_stop", 0, 0, 1, 0, 2'd0);
    release_inputs();
    cyc("t1_once", 0, 0, 1, 0, 2'd0);

    // 2: timeout after 60 ticks, stays armed, re-fires next day
    set_time(7, 30, 1);
    cyc("t2_gap", 0, 0, 1, 0, 2'd0);
    set_time(7, 30, 0);
    cyc("t2_fire", 1, 0, 1, 0, 2'd0);
    for (int i = 0; i < 59; i++) begin
      sec_tick = 1'b1;
      step();
      sec_tick = 1'b0;
    end
    cyc("t2_tick59", 1, 0, 1, 0, 2'd0);
    sec_tick = 1'b1;
    cyc("t2_tick60", 0, 0, 1, 0, 2'd0);
    sec_tick = 1'b0;
    set_time(7, 30, 1);
    cyc("t2_nextday_gap", 0, 0, 1, 0, 2'd0);
    set_time(7, 30, 0);
    cyc("t2_refire", 1, 0, 1, 0, 2'd0);
    stop_button = 1'b1;
    cyc("t2_stop", 0, 0, 1, 0, 2'd0);
    release_inputs();

    // 3: ring at 23:58, snooze wraps to 00:03
    load(23, 58, 1'b1);
    set_time(23, 57, 59);
    cyc("t3_load", 0, 0, 1, 0, 2'd0);
    release_inputs();
    set_time(23, 58, 0);
    cyc("t3_fire", 1, 0, 1, 0, 2'd0);
    snooze_button = 1'b1;
    cyc("t3_snooze", 0, 1, 1, 0, 2'd1);
    release_inputs();
    set_time(0, 2, 59);
    cyc("t3_wait", 0, 1, 1, 0, 2'd1);
    set_time(0, 3, 0);
    cyc("t3_refire", 1, 0, 1, 0, 2'd1);

    // 4: snooze limit, then stop+snooze same cycle, then stop from snoozing
    snooze_button = 1'b1;
    cyc("t4_snooze2", 0, 1, 1, 0, 2'd2);
    release_inputs();
    set_time(0, 8, 0);
    cyc("t4_ring2", 1, 0, 1, 0, 2'd2);
    snooze_button = 1'b1;
    cyc("t4_snooze3", 0, 1, 1, 0, 2'd3);
    release_inputs();
    set_time(0, 13, 0);
    cyc("t4_ring3", 1, 0, 1, 0, 2'd3);
    snooze_button = 1'b1;
    cyc("t4_snooze4_stops", 0, 0, 1, 0, 2'd3);
    release_inputs();
    set_time(23, 58, 1);
    cyc("t4_gap", 0, 0, 1, 0, 2'd3);
    set_time(23, 58, 0);
    cyc("t4_fire", 1, 0, 1, 0, 2'd0);
    stop_button = 1'b1;
    snooze_button = 1'b1;
    cyc("t4_stop_wins", 0, 0, 1, 0, 2'd0);
    release_inputs();
    set_time(23, 58, 1);
    cyc("t4_gap2", 0, 0, 1, 0, 2'd0);
    set_time(23, 58, 0);
    cyc("t4_fire2", 1, 0, 1, 0, 2'd0);
    snooze_button = 1'b1;
    cyc("t4_snooze_again", 0, 1, 1, 0, 2'd1);
    release_inputs();
    stop_button = 1'b1;
    cyc("t4_stop_snoozing", 0, 0, 1, 0, 2'd0);
    release_inputs();

    // 5: invalid 24:10 never rings
    load(24, 10, 1'b1);
    set_time(0, 9, 59);
    cyc("t5_load", 0, 0, 0, 1, 2'd0);
    release_inputs();
    set_time(0, 10, 0);
    cyc("t5_wrap", 0, 0, 0, 1, 2'd0);
    set_time(24, 10, 59);
    cyc("t5_pre24", 0, 0, 0, 1, 2'd0);
    set_time(24, 10, 0);
    cyc("t5_24", 0, 0, 0, 1, 2'd0);

    // 6: disable-load cancels ring; async reset mid-ring
    load(7, 30, 1'b1);
    set_time(7, 29, 59);
    cyc("t6_load", 0, 0, 1, 0, 2'd0);
    release_inputs();
    set_time(7, 30, 0);
    cyc("t6_fire", 1, 0, 1, 0, 2'd0);
    load(7, 30, 1'b0);
    cyc("t6_cancel", 0, 0, 0, 0, 2'd0);
    release_inputs();
    load(7, 30, 1'b1);
    set_time(7, 29, 59);
    cyc("t6_reload", 0, 0, 1, 0, 2'd0);
    release_inputs();
    set_time(7, 30, 0);
    cyc("t6_fire2", 1, 0, 1, 0, 2'd0);
    #2;
    rst = 1'b0;
    #1;
    expect_out("t6_async_rst", 0, 0, 0, 0, 2'd0);
    check_outputs();
    #1;
    rst = 1'b1;
    set_time(7, 29, 59);
    cyc("t6_after_rst", 0, 0, 0, 0, 2'd0);
    set_time(7, 30, 0);
    cyc("t6_cleared", 0, 0, 0, 0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
